// File: rtl/mem_copy_master.sv
// mem_copy_master: word-by-word memory copy engine (read src+i, write dst+i).
// Every access waits for the memory done strobe and is abandoned after
// TIMEOUT cycles, which ends the transfer with err set.
// Optional feature: define MEM_COPY_FILL_EN to add fill_en/fill_value ports.
// In fill mode the read phase is skipped and fill_value is written to each word.
module mem_copy_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
`ifdef MEM_COPY_FILL_EN
    input  logic              fill_en,
    input  logic [DATA_W-1:0] fill_value,
`endif
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_read_signal,
    output logic              mem_write_signal,
    input  logic [DATA_W-1:0] mem_dataout,
    input  logic              mem_doneRead,
    input  logic              mem_doneWrite
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   src_q, dst_q, len_q, idx_q;
    logic [CW-1:0]       cnt_q;
    logic                busy_q, done_q, err_q, rd_q, wr_q, fill_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q, fval_q;

    // Start-time fill selection; constant zero when the feature is compiled out.
    logic                fill_start;
    logic [DATA_W-1:0]   fill_word;
`ifdef MEM_COPY_FILL_EN
    assign fill_start = fill_en;
    assign fill_word  = fill_value;
`else
    assign fill_start = 1'b0;
    assign fill_word  = '0;
`endif

    // Next word index after the current write completes.
    logic [ADDR_W-1:0]   idx_d;
    assign idx_d = idx_q + 1'b1;

    // Wait counter is zero only on the entry cycle of an access, so a done
    // flag left high by the memory from the previous access is ignored there.
    logic                wait_ok, wait_exp;
    assign wait_ok  = (cnt_q != '0);
    assign wait_exp = (cnt_q == CW'(TIMEOUT - 1));

    // Single FSM: all outputs are registers updated on transitions.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            fill_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            fval_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        len_q  <= length;
                        idx_q  <= '0;
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        fill_q <= fill_start;
                        fval_q <= fill_word;
                        if (length == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (fill_start) begin
                            state_q <= WR;
                            wr_q    <= 1'b1;
                            addr_q  <= dst_addr;
                            data_q  <= fill_word;
                        end else begin
                            state_q <= RD;
                            rd_q    <= 1'b1;
                            addr_q  <= src_addr;
                        end
                    end
                end
                RD: begin
                    if (wait_ok && mem_doneRead) begin
                        data_q  <= mem_dataout;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b1;
                        addr_q  <= dst_q + idx_q;
                        cnt_q   <= '0;
                        state_q <= WR;
                    end else if (wait_exp) begin
                        rd_q    <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                WR: begin
                    if (wait_ok && mem_doneWrite) begin
                        idx_q <= idx_d;
                        cnt_q <= '0;
                        if (idx_d == len_q) begin
                            wr_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (fill_q) begin
                            // Back-to-back writes: strobe stays high, address moves.
                            addr_q  <= dst_q + idx_d;
                            data_q  <= fval_q;
                        end else begin
                            wr_q    <= 1'b0;
                            rd_q    <= 1'b1;
                            addr_q  <= src_q + idx_d;
                            state_q <= RD;
                        end
                    end else if (wait_exp) begin
                        wr_q    <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
    assign mem_address      = addr_q;
    assign mem_data         = data_q;
    assign mem_read_signal  = rd_q;
    assign mem_write_signal = wr_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: behavioural memory answering on the falling edge
// with a programmable latency, and a sequential copy reference model.
module tb_mem_copy_master;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          RST;
    logic          start;
    logic [AW-1:0] src_addr, dst_addr, length;
    logic          busy, done, err;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_read_signal, mem_write_signal;
    logic [DW-1:0] mem_dataout;
    logic          mem_doneRead, mem_doneWrite;
`ifdef MEM_COPY_FILL_EN
    logic          fill_en;
    logic [DW-1:0] fill_value;
`endif

    mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .RST(RST), .start(start),
`ifdef MEM_COPY_FILL_EN
        .fill_en(fill_en), .fill_value(fill_value),
`endif
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .err(err),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_read_signal(mem_read_signal), .mem_write_signal(mem_write_signal),
        .mem_dataout(mem_dataout), .mem_doneRead(mem_doneRead),
        .mem_doneWrite(mem_doneWrite)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory model state
    logic [DW-1:0] mem   [0:65535];
    logic [DW-1:0] ref_m [0:65535];
    int            lat   = 0;
    logic          rd_en = 1'b1;
    logic          wr_en = 1'b1;
    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] wr_log[$];
    int            both_hi = 0;
    logic          rd_p = 1'b0, wr_p = 1'b0;
    logic [AW-1:0] addr_p = '0;
    int            age = 0;

    // Memory: responds on the falling edge once a strobe has been held > lat cycles.
    always @(negedge clk) begin
        if (mem_read_signal && mem_write_signal) both_hi = both_hi + 1;
        if (!(mem_read_signal || mem_write_signal)) age = 0;
        else if (rd_p == mem_read_signal && wr_p == mem_write_signal && addr_p == mem_address) age = age + 1;
        else age = 1;
        if (mem_read_signal && (!rd_p || addr_p != mem_address)) rd_log.push_back(mem_address);
        if (mem_write_signal && (!wr_p || addr_p != mem_address)) wr_log.push_back(mem_address);
        mem_doneRead = mem_read_signal && rd_en && (age > lat);
        if (mem_read_signal) mem_dataout = mem[mem_address];
        mem_doneWrite = mem_write_signal && wr_en && (age > lat);
        if (mem_doneWrite) mem[mem_address] = mem_data;
        rd_p   = mem_read_signal;
        wr_p   = mem_write_signal;
        addr_p = mem_address;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start for one edge; returns just after the accepting edge.
    task automatic go(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l);
        rd_log.delete();
        wr_log.delete();
        src_addr = s;
        dst_addr = d;
        length   = l;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, mem_read_signal, mem_write_signal} !== 5'b0 ||
            mem_address !== 16'h0 || mem_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b err=%b rd=%b wr=%b addr=%h data=%h, all required 0",
                     busy, done, err, mem_read_signal, mem_write_signal, mem_address, mem_data);
        end
        repeat (2) tick();
        #2 RST = 1'b0;
        tick();
    endtask

    task automatic test_copy_basic();
        int n;
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            mem[16'h0010 + i] = 16'hA0 + 16'(i);
            mem[16'h0100 + i] = 16'h0;
        end
        go(16'h0010, 16'h0100, 16'd4);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL copy_busy: got %b want 1", busy); end
        wait_done(n);
        checks++;
        if (n != 16) begin errors++; $display("FAIL copy_latency: got %0d want 16", n); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL copy_err: got %b want 0", err); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[16'h0100 + i] !== 16'hA0 + 16'(i)) begin
                errors++;
                $display("FAIL copy_word%0d: got %h want %h", i, mem[16'h0100 + i], 16'hA0 + 16'(i));
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL copy_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_length_zero();
        int n;
        go(16'h1234, 16'h4321, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL len0_done: done=%b busy=%b want 1 1", done, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL len0_idle: busy=%b done=%b want 0 0", busy, done);
        end
        n = rd_log.size() + wr_log.size();
        checks++;
        if (n != 0) begin errors++; $display("FAIL len0_strobes: got %0d accesses want 0", n); end
    endtask

    task automatic test_wrap();
        int n;
        logic [AW-1:0] exp_rd [3];
        exp_rd = '{16'hFFFE, 16'hFFFF, 16'h0000};
        lat = 1;
        go(16'hFFFE, 16'h0300, 16'd3);
        wait_done(n);
        checks++;
        if (rd_log.size() != 3) begin
            errors++;
            $display("FAIL wrap_nreads: got %0d want 3", rd_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rd_log[i] !== exp_rd[i]) begin
                    errors++;
                    $display("FAIL wrap_read%0d: got %h want %h", i, rd_log[i], exp_rd[i]);
                end
            end
        end
        checks++;
        if (mem[16'h0302] !== mem[16'h0000]) begin
            errors++;
            $display("FAIL wrap_data: got %h want %h", mem[16'h0302], mem[16'h0000]);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        lat   = 0;
        rd_en = 1'b0;
        go(16'h0500, 16'h0600, 16'd2);
        wait_done(n);
        checks++;
        if (n != TO) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", n, TO); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err); end
        checks++;
        if (mem_read_signal !== 1'b0 || mem_write_signal !== 1'b0) begin
            errors++;
            $display("FAIL timeout_strobes: rd=%b wr=%b want 0 0", mem_read_signal, mem_write_signal);
        end
        checks++;
        if (wr_log.size() != 0) begin errors++; $display("FAIL timeout_writes: got %0d want 0", wr_log.size()); end
        rd_en = 1'b1;
        repeat (2) tick();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
        go(16'h0, 16'h0, 16'd0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
        tick();
    endtask

    task automatic test_reset_midway();
        int n, g;
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            mem[16'h0700 + i] = 16'hC0DE + 16'(i);
            mem[16'h0800 + i] = 16'hDEAD;
        end
        go(16'h0700, 16'h0800, 16'd4);
        g = 0;
        while (wr_log.size() < 2 && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        checks++;
        if (wr_log.size() < 2) begin errors++; $display("FAIL rst_mid_reach: got %0d writes want 2", wr_log.size()); end
        RST = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, mem_read_signal, mem_write_signal} !== 5'b0 ||
            mem_address !== 16'h0 || mem_data !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: busy=%b done=%b err=%b rd=%b wr=%b addr=%h data=%h, want all 0",
                     busy, done, err, mem_read_signal, mem_write_signal, mem_address, mem_data);
        end
        n = 0;
        repeat (3) begin
            tick();
            if (done === 1'b1) n++;
        end
        #2 RST = 1'b0;
        repeat (3) begin
            tick();
            if (done === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL rst_mid_nodone: got %0d done cycles want 0", n); end
        checks++;
        if (mem[16'h0800] !== 16'hC0DE || mem[16'h0802] !== 16'hDEAD) begin
            errors++;
            $display("FAIL rst_mid_partial: got %h %h want c0de dead", mem[16'h0800], mem[16'h0802]);
        end
        go(16'h0700, 16'h0800, 16'd4);
        wait_done(n);
        checks++;
        if (n != 16 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_restart: latency %0d err %b want 16 0", n, err);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[16'h0800 + i] !== 16'hC0DE + 16'(i)) begin
                errors++;
                $display("FAIL rst_mid_word%0d: got %h want %h", i, mem[16'h0800 + i], 16'hC0DE + 16'(i));
            end
        end
        tick();
    endtask

    // Random copies, random memory latency, some with start held high while busy.
    task automatic test_random();
        int n, extra, per, exp_n, bad;
        logic [AW-1:0] s, d, l;
        for (int it = 0; it < 8; it++) begin
            s   = 16'($urandom);
            d   = (it % 3 == 0) ? s + 16'($urandom_range(1, 4)) : 16'($urandom);
            l   = 16'($urandom_range(1, 8));
            lat = $urandom_range(0, 4);
            for (int a = 0; a < 65536; a++) ref_m[a] = mem[a];
            for (int i = 0; i < int'(l); i++) ref_m[16'(d + 16'(i))] = ref_m[16'(s + 16'(i))];
            go(s, d, l);
            extra = 0;
            if (it % 2 == 1) begin
                repeat (5) begin
                    src_addr = 16'($urandom);
                    dst_addr = 16'($urandom);
                    length   = 16'($urandom_range(1, 9));
                    start    = 1'b1;
                    tick();
                    extra++;
                end
                start = 1'b0;
            end
            wait_done(n);
            n   = n + extra;
            per = (lat + 1 > 2) ? lat + 1 : 2;
            exp_n = 2 * int'(l) * per;
            checks++;
            if (n != exp_n) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", it, n, exp_n); end
            checks++;
            if (err !== 1'b0) begin errors++; $display("FAIL rand%0d_err: got %b want 0", it, err); end
            bad = 0;
            for (int a = 0; a < 65536; a++) if (mem[a] !== ref_m[a]) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL rand%0d_mem: got %0d differing words want 0", it, bad); end
            tick();
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_idle: busy=%b want 0", it, busy); end
        end
    endtask

`ifdef MEM_COPY_FILL_EN
    task automatic test_fill();
        int n;
        lat = 0;
        for (int i = 0; i < 3; i++) mem[16'h0200 + i] = 16'h0;
        fill_en    = 1'b1;
        fill_value = 16'h5A5A;
        go(16'h0040, 16'h0200, 16'd3);
        fill_en    = 1'b0;
        wait_done(n);
        checks++;
        if (n != 6) begin errors++; $display("FAIL fill_latency: got %0d want 6", n); end
        checks++;
        if (rd_log.size() != 0) begin errors++; $display("FAIL fill_reads: got %0d want 0", rd_log.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[16'h0200 + i] !== 16'h5A5A) begin
                errors++;
                $display("FAIL fill_word%0d: got %h want 5a5a", i, mem[16'h0200 + i]);
            end
        end
        tick();
    endtask
`endif

    initial begin
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length = '0;
        mem_dataout = '0;
        mem_doneRead = 1'b0;
        mem_doneWrite = 1'b0;
`ifdef MEM_COPY_FILL_EN
        fill_en = 1'b0;
        fill_value = '0;
`endif
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        test_reset();
        test_copy_basic();
        test_length_zero();
        test_wrap();
        test_timeout();
        test_reset_midway();
        test_random();
`ifdef MEM_COPY_FILL_EN
        test_fill();
`endif
        checks++;
        if (both_hi != 0) begin errors++; $display("FAIL strobe_exclusive: got %0d overlap cycles want 0", both_hi); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
